// File: rtl/quasi_burst_pkg.sv
// Shared types and constants for the burst sequencer.
// The state encoding and the length decode live here so the bench and RTL agree.
package quasi_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_OUT,
        S_WR_WAIT,
        S_WR_ISSUE,
        S_DONE
    } state_t;

    localparam logic [8:0] BURST_MAX = 9'd256;

    // A zero length field stands for a full 256-word burst.
    function automatic logic [8:0] decode_len(input logic [7:0] len);
        return (len == 8'd0) ? BURST_MAX : {1'b0, len};
    endfunction

endpackage

// File: rtl/burst_timeout.sv
// Per-access m_ready wait counter.
// expired fires on the cycle the count would reach LIMIT.
module burst_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = inc && !clr && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/burst_sequencer.sv
// Word-burst sequencer between a stream port and a simple memory port.
// All outputs come straight from flops; m_ready only steers next state.
module burst_sequencer
    import quasi_burst_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        burst_req,
    input  logic        burst_we,
    input  logic [31:0] burst_addr,
    input  logic [7:0]  burst_len,
    output logic        burst_busy,
    output logic        burst_done,
    output logic        burst_err,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] m_a,
    output logic [31:0] m_d,
    output logic        m_we,
    output logic        m_rd,
    input  logic [31:0] m_spo,
    input  logic        m_ready
);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] rdata_q;
    logic [31:0] m_d_q;
    logic [8:0]  cnt_q;
    logic [8:0]  cnt_d;
    logic        m_rd_q;
    logic        m_we_q;
    logic        wready_q;
    logic        rvalid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        issue;
    logic        last;
    logic        expired;

    assign addr_d = addr_q + 32'(ADDR_STEP);
    assign cnt_d  = cnt_q - 9'd1;
    assign last   = (cnt_q == 9'd1);
    assign issue  = (state_q == S_RD_ISSUE) ||
                    (state_q == S_WR_ISSUE);

    // Held clear outside the ISSUE states, so each access starts at zero.
    burst_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!issue),
        .inc    (issue && !m_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            m_d_q    <= '0;
            m_rd_q   <= 1'b0;
            m_we_q   <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (burst_req) begin
                        addr_q <= burst_addr;
                        cnt_q  <= decode_len(burst_len);
                        busy_q <= 1'b1;
                        if (burst_we) begin
                            state_q  <= S_WR_WAIT;
                            wready_q <= 1'b1;
                        end else begin
                            state_q <= S_RD_ISSUE;
                            m_rd_q  <= 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    if (m_ready) begin
                        rdata_q  <= m_spo;
                        m_rd_q   <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RD_OUT;
                    end else if (expired) begin
                        m_rd_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_RD_OUT: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        cnt_q    <= cnt_d;
                        addr_q   <= addr_d;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            m_rd_q  <= 1'b1;
                            state_q <= S_RD_ISSUE;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (wvalid) begin
                        m_d_q    <= wdata;
                        wready_q <= 1'b0;
                        m_we_q   <= 1'b1;
                        state_q  <= S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    if (m_ready) begin
                        m_we_q <= 1'b0;
                        cnt_q  <= cnt_d;
                        addr_q <= addr_d;
                        if (last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            wready_q <= 1'b1;
                            state_q  <= S_WR_WAIT;
                        end
                    end else if (expired) begin
                        m_we_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign burst_busy = busy_q;
    assign burst_done = done_q;
    assign burst_err  = err_q;
    assign wready     = wready_q;
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign m_a        = addr_q;
    assign m_d        = m_d_q;
    assign m_we       = m_we_q;
    assign m_rd       = m_rd_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Bench for burst_sequencer: memory/stream responders, a transaction-level
// model that predicts addresses, data and completion, and directed bursts.
module tb_burst_sequencer;

    localparam int TO   = 8;
    localparam int STEP = 4;
    localparam logic [31:0] MEMX = 32'h5A5A_1234;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        burst_req = 1'b0;
    logic        burst_we = 1'b0;
    logic [31:0] burst_addr = '0;
    logic [7:0]  burst_len = '0;
    logic        burst_busy, burst_done, burst_err;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] m_a, m_d, m_spo;
    logic        m_we, m_rd;
    logic        m_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    burst_sequencer #(
        .TIMEOUT(TO),
        .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst),
        .burst_req(burst_req), .burst_we(burst_we),
        .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_busy(burst_busy), .burst_done(burst_done),
        .burst_err(burst_err),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_rd(m_rd),
        .m_spo(m_spo), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the address.
    assign m_spo = m_a ^ MEMX;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory responder: completes an access lat cycles after the strobe.
    int lat = 0;
    bit hold = 0;
    bit stray = 0;
    int wc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if ((m_rd || m_we) && !hold) begin
                m_ready = (wc >= lat);
                wc++;
            end else begin
                m_ready = stray && !(m_rd || m_we);
                wc = 0;
            end
        end
    end

    // Write stream source: offers a word wdly cycles after wready rises.
    int wdly = 0;
    int wd = 0;
    int wi = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wvalid) begin
                wvalid = 1'b0;
                wi++;
            end else if (wready) begin
                if (wd >= wdly) begin
                    wvalid = 1'b1;
                    wdata = 32'hC0DE_0000 + 32'(wi);
                    wd = 0;
                end else begin
                    wd++;
                end
            end else begin
                wd = 0;
            end
        end
    end

    // Read stream sink: always ready, or ready every third cycle.
    bit slow = 0;
    int rc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rc++;
            rready = !slow || (rc % 3 == 0);
        end
    end

    // Transaction model.
    logic [31:0] exp_start = '0;
    int          exp_len = 0;
    bit          exp_we = 0;
    bit          exp_err = 0;
    int          acc_idx = 0;
    int          beat = 0;
    int          done_cnt = 0;
    int          rd_hi = 0;
    logic [31:0] last_a = '0;
    logic [31:0] wq[$];
    logic        prev_done = 1'b0;

    function automatic logic [31:0] eaddr(input int i);
        return exp_start + 32'(i * STEP);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_we_excl", 32'(m_rd & m_we), 0);
            if (prev_done) chk("done_one_cycle", 32'(burst_done), 0);
            prev_done = burst_done;
            if (m_rd || m_we) chk("m_a", m_a, eaddr(acc_idx));
            if (m_rd) rd_hi++;
            if (wvalid && wready) wq.push_back(wdata);
            if (m_we) begin
                chk("we_after_wvalid", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) chk("m_d", m_d, wq[0]);
            end
            if ((m_rd || m_we) && m_ready) begin
                last_a = m_a;
                acc_idx++;
                if (m_we && wq.size() > 0) void'(wq.pop_front());
            end
            if (rvalid) chk("rdata", rdata, eaddr(beat) ^ MEMX);
            if (rvalid && rready) beat++;
            if (burst_done) begin
                done_cnt++;
                chk("busy_at_done", 32'(burst_busy), 1);
                chk("err", 32'(burst_err), 32'(exp_err));
                chk("accesses", 32'(acc_idx),
                    exp_err ? 0 : 32'(exp_len));
                if (!exp_we && !exp_err)
                    chk("beats", 32'(beat), 32'(exp_len));
            end
        end
    end

    task automatic start(input bit we, input logic [31:0] a,
                         input logic [7:0] len, input bit err);
        exp_start = a;
        exp_len = (len == 8'd0) ? 256 : int'(len);
        exp_we = we;
        exp_err = err;
        acc_idx = 0;
        beat = 0;
        rd_hi = 0;
        done_cnt = 0;
        wq.delete();
        @(posedge clk);
        #1;
        burst_req = 1'b1;
        burst_we = we;
        burst_addr = a;
        burst_len = len;
        @(posedge clk);
        #1;
        burst_req = 1'b0;
        chk("busy_after_req", 32'(burst_busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
        @(negedge clk);
        #1;
        chk("busy_idle", 32'(burst_busy), 0);
        chk("done_count", 32'(done_cnt), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dn;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bits", 32'({burst_busy, burst_done, burst_err,
                             wready, rvalid, m_we, m_rd}), 0);
        chk("rst_m_a", m_a, 0);
        chk("rst_m_d", m_d, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stray m_ready while idle does nothing.
        stray = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_busy", 32'(burst_busy), 0);
        chk("stray_strobe", 32'({m_rd, m_we, rvalid}), 0);
        stray = 0;

        // Read 0x100 x3, memory ready after one cycle.
        lat = 1;
        start(0, 32'h100, 8'd3, 0);
        wait_done(100);
        chk("t1_last_a", last_a, 32'h108);

        // Write x2, slow stream; requests during the burst are ignored.
        lat = 0;
        wdly = 5;
        start(1, 32'h2000, 8'd2, 0);
        burst_req = 1'b1;
        burst_we = 1'b0;
        burst_addr = 32'hDEAD_0000;
        repeat (3) @(posedge clk);
        #1;
        burst_req = 1'b0;
        wait_done(200);
        chk("t2_last_a", last_a, 32'h2004);
        chk("t2_words", 32'(acc_idx), 2);

        // Length 0 means 256 words.
        start(0, 32'h4000, 8'd0, 0);
        wait_done(1200);
        chk("t3_count", 32'(acc_idx), 256);
        chk("t3_last_a", last_a, 32'h43FC);

        // Address wraps past the top of the space.
        start(0, 32'hFFFF_FFFC, 8'd2, 0);
        wait_done(100);
        chk("t4_last_a", last_a, 32'h0000_0000);

        // Timeout: strobe held TO cycles, then error completion.
        hold = 1;
        start(0, 32'h500, 8'd1, 1);
        wait_done(50);
        chk("t5_strobe_cycles", 32'(rd_hi), 32'(TO));
        hold = 0;
        start(0, 32'h600, 8'd1, 0);
        wait_done(50);
        chk("t5_recover_a", last_a, 32'h600);

        // Reset in the middle of the second word of a 4-word read.
        lat = 1;
        start(0, 32'h800, 8'd4, 0);
        n = 0;
        while (!(acc_idx == 1 && m_rd) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_reached_word2", 32'(acc_idx == 1 && m_rd), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_bits", 32'({burst_busy, burst_done, burst_err,
                                wready, rvalid, m_we, m_rd}), 0);
        chk("t6_rst_m_a", m_a, 0);
        chk("t6_rst_rdata", rdata, 0);
        dn = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_done", 32'(done_cnt), 32'(dn));

        // Normal burst after reset, with a slow read sink.
        slow = 1;
        start(0, 32'h900, 8'd4, 0);
        wait_done(200);
        chk("t6_last_a", last_a, 32'h90C);
        slow = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
